d_flipflop: RTL and testbench
=============================

// Module: d_flipflop
// PURPOSE
//   Positive-edge D flip-flop with a synchronous active-high reset and
//   complementary outputs. Generic storage primitive used wherever a
//   one-cycle registered delay of a signal is needed.
//   It is parameterised in width and reset value.
//   Default configuration is a 1-bit register that resets to 0.
// PARAMETERS
//   WIDTH    1   data width in bits; legal range is WIDTH >= 1
//   RST_VAL  0   value loaded into q on reset, WIDTH bits wide
// PORTS
//   clk   in   1      single clock; all state changes on rising edge only
//   rst   in   1      reset; synchronous, active-high
//   d     in   WIDTH  data input, sampled at the rising edge of clk
//   q     out  WIDTH  registered output
//   qbar  out  WIDTH  bitwise complement of q
//   Positional port order is fixed: (d, clk, rst, q, qbar).
// BEHAVIOUR
//   - Latency: one clock. At each rising clk edge with rst=0, q <= d.
//   - Reset: at a rising clk edge with rst=1, q <= RST_VAL and d is ignored.
//     Reset takes priority over d.
//     rst asserted between edges has no effect until the next rising edge.
//   - No asynchronous path: changes on rst or d between edges never alter q.
//   - qbar is combinational: qbar == ~q at all times, bit for bit,
//     with no extra register stage.
//   - Power-up: q and qbar are undefined (X in simulation) until the first
//     rising edge. There is no initial value.
//   - Deassertion: when rst is released, the first edge with rst=0 loads d
//     normally. No extra recovery cycle.
//   - Hold: q holds its value between rising edges regardless of d glitches.
//   - Reset mid-stream: a reset edge overrides the data sampled on that edge.
//     The next non-reset edge resumes capture of d.
// TESTING
//   Clock period is 4 time units; the first rising edge is at t=2.
//   1. rst=0, d=0 from t=0 -> after edge at t=2: q=0, qbar=1.
//   2. d=1, rst=0 at an edge -> q=1, qbar=0 within 1 time unit after that edge;
//      then d=0 at the next edge -> q=0, qbar=1.
//   3. rst=1 with d=1 across an edge -> q=RST_VAL (0), qbar=1.
//      q stays 0 on further edges while rst=1.
//   4. rst 1->0 with d=1 -> q=1 on the first edge after release (no extra cycle).
//   5. Toggle d and rst mid-period (not at an edge) -> q unchanged until the
//      next rising edge. qbar==~q at every sample.
//   6. Ten random d values, one per edge, with a reset pulse in between ->
//      q equals d from the prior edge, except on the reset edge where q=0.
//      Dump waves to a VCD file for inspection.

Source files
------------

// File: rtl/d_flipflop.sv
// Rising-edge D register with synchronous active-high reset and a
// combinational complementary output. Width and reset value are parameters.
module d_flipflop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // No initial value: q is X until the first rising edge, reset wins over d.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign qbar = ~q;

endmodule

// File: tb/tb_d_flipflop.sv
// Bench for d_flipflop: a default 1-bit instance and an 8-bit instance with a
// non-zero reset value, both checked against a queue of expected edge results.
module tb_d_flipflop;

    localparam logic [7:0] RST8 = 8'hA5;

    // clock/reset block: period 4, first rising edge at t=2
    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic       rst = 1'b0;
    logic       d1  = 1'b0;
    logic [7:0] d8  = 8'h00;
    logic       q1, qbar1;
    logic [7:0] q8, qbar8;

    d_flipflop u_dut1 (
        .d    (d1),
        .clk  (clk),
        .rst  (rst),
        .q    (q1),
        .qbar (qbar1)
    );

    d_flipflop #(.WIDTH(8), .RST_VAL(RST8)) u_dut8 (
        .d    (d8),
        .clk  (clk),
        .rst  (rst),
        .q    (q8),
        .qbar (qbar8)
    );

    // scoreboard: one expected value per rising edge, per instance
    logic [0:0] exp1_q[$];
    logic [7:0] exp8_q[$];
    logic       last1;
    logic [7:0] last8;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Apply inputs, let one rising edge pass, then compare 1 time unit later.
    task automatic step(input logic [7:0] dv, input logic rv, input string tag);
        d1  = dv[0];
        d8  = dv;
        rst = rv;
        exp1_q.push_back(rv ? 1'b0 : dv[0]);
        exp8_q.push_back(rv ? RST8 : dv);
        @(posedge clk);
        #1;
        last1 = exp1_q.pop_front();
        last8 = exp8_q.pop_front();
        check({tag, "_q1"},    {7'b0, q1},    {7'b0, last1});
        check({tag, "_qbar1"}, {7'b0, qbar1}, {7'b0, ~last1});
        check({tag, "_q8"},    q8,            last8);
        check({tag, "_qbar8"}, qbar8,         ~last8);
    endtask

    // Between edges: outputs must still show the last captured value.
    task automatic hold_check(input string tag);
        check({tag, "_q1"},    {7'b0, q1},    {7'b0, last1});
        check({tag, "_qbar1"}, {7'b0, qbar1}, {7'b0, ~last1});
        check({tag, "_q8"},    q8,            last8);
        check({tag, "_qbar8"}, qbar8,         ~last8);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv8;
        logic       rr;

        // 1. zero in, no reset, from t=0
        step(8'h00, 1'b0, "zero");
        // 2. capture 1 then 0
        step(8'hFF, 1'b0, "cap_one");
        step(8'h3C, 1'b0, "cap_zero");
        // 3. reset held with d=1
        step(8'hFF, 1'b1, "rst_a");
        step(8'hFF, 1'b1, "rst_b");
        step(8'h5B, 1'b1, "rst_c");
        // 4. release: first edge loads d
        step(8'hC3, 1'b0, "release");
        // 5. mid-period toggles of d and rst do nothing until the next edge
        d1 = ~d1; d8 = ~d8; rst = 1'b1;
        #1;
        hold_check("mid_a");
        d1 = ~d1; d8 = 8'h0F; rst = 1'b0;
        #1;
        hold_check("mid_b");
        step(8'h96, 1'b0, "after_mid");

        // 6. ten random values with a reset pulse in the middle
        for (int i = 0; i < 10; i++) begin
            rv8 = 8'($urandom_range(0, 255));
            step(rv8, (i == 5), "rand10");
        end

        // extra random traffic with sporadic resets and mid-period glitches
        for (int i = 0; i < 40; i++) begin
            rv8 = 8'($urandom_range(0, 255));
            rr  = ($urandom_range(0, 6) == 0);
            step(rv8, rr, "rand");
            if ($urandom_range(0, 3) == 0) begin
                d8  = 8'($urandom_range(0, 255));
                d1  = d8[0];
                rst = 1'($urandom_range(0, 1));
                #1;
                hold_check("glitch");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
